// File: rtl/hsid_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : hsid_rst_seq
// Brief    : Reset sequencer. Asserts NUM_CH active-low resets together and
//            releases them one by one after a minimum hold time.
//            Optional macro HSID_RST_SEQ_ASYNC_ASSERT_EN gates the outputs
//            with the raw external request for immediate assertion.
// Revision : 1.0 - initial release
// ============================================================================
module hsid_rst_seq #(
    parameter int NUM_CH         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_req_async_n,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              seq_busy,
    output logic              seq_done,
    output logic [1:0]        rst_cause
);

    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_STAG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int c_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_STAG_W-1:0] c_STAG_LAST = c_STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [c_CH_W-1:0]   c_CH_LAST   = c_CH_W'(NUM_CH - 1);
    localparam logic [c_CH_W-1:0]   c_CH_FIRST  = c_CH_W'(1);

    localparam logic [1:0] c_ST_ASSERT  = 2'd0;
    localparam logic [1:0] c_ST_RELEASE = 2'd1;
    localparam logic [1:0] c_ST_RUN     = 2'd2;

    localparam logic [1:0] c_CAUSE_POR = 2'b00;
    localparam logic [1:0] c_CAUSE_EXT = 2'b01;
    localparam logic [1:0] c_CAUSE_SW  = 2'b10;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [c_HOLD_W-1:0]    r_hold_cnt;
    logic [c_STAG_W-1:0]    r_stag_cnt;
    logic [c_CH_W-1:0]      r_ch_idx;
    logic [NUM_CH-1:0]      r_rst_n;
    logic                   r_busy;
    logic                   r_done;
    logic [1:0]             r_cause;

    logic [1:0]             w_state_nxt;
    logic [c_HOLD_W-1:0]    w_hold_nxt;
    logic [c_STAG_W-1:0]    w_stag_nxt;
    logic [c_CH_W-1:0]      w_ch_idx_nxt;
    logic [NUM_CH-1:0]      w_rst_n_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic [1:0]             w_cause_nxt;

    logic                   w_req_s;
    logic                   w_new_req;
    logic [NUM_CH-1:0]      w_ch_mask;

    // Flops idle at 1 so a power-on reset never looks like an external request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rst_req_async_n};
        end
    end

    assign w_req_s   = ~r_sync[SYNC_STAGES-1];
    assign w_new_req = w_req_s | sw_rst_req;

    // One-hot select of the channel due for release, safe for any NUM_CH.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch_mask
            assign w_ch_mask[i] = (r_ch_idx == c_CH_W'(i));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_ASSERT;
            r_hold_cnt <= '0;
            r_stag_cnt <= '0;
            r_ch_idx   <= c_CH_FIRST;
            r_rst_n    <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_cause    <= c_CAUSE_POR;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_stag_cnt <= w_stag_nxt;
            r_ch_idx   <= w_ch_idx_nxt;
            r_rst_n    <= w_rst_n_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_cause    <= w_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold_cnt;
        w_stag_nxt   = r_stag_cnt;
        w_ch_idx_nxt = r_ch_idx;
        w_rst_n_nxt  = r_rst_n;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_cause_nxt  = r_cause;

        if (w_new_req) begin
            // External wins when both requests coincide.
            w_state_nxt = c_ST_ASSERT;
            w_rst_n_nxt = '0;
            w_hold_nxt  = '0;
            w_busy_nxt  = 1'b1;
            w_cause_nxt = w_req_s ? c_CAUSE_EXT : c_CAUSE_SW;
        end else begin
            case (r_state)
                c_ST_ASSERT: begin
                    if (r_hold_cnt != c_HOLD_LAST) begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end else if (NUM_CH == 1) begin
                        w_state_nxt = c_ST_RUN;
                        w_rst_n_nxt = '1;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt    = c_ST_RELEASE;
                        w_rst_n_nxt[0] = 1'b1;
                        w_ch_idx_nxt   = c_CH_FIRST;
                        w_stag_nxt     = '0;
                    end
                end
                c_ST_RELEASE: begin
                    if (r_stag_cnt != c_STAG_LAST) begin
                        w_stag_nxt = r_stag_cnt + 1'b1;
                    end else begin
                        w_rst_n_nxt = r_rst_n | w_ch_mask;
                        w_stag_nxt  = '0;
                        if (r_ch_idx == c_CH_LAST) begin
                            w_state_nxt = c_ST_RUN;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_ch_idx_nxt = r_ch_idx + 1'b1;
                        end
                    end
                end
                c_ST_RUN: begin
                    w_rst_n_nxt = '1;
                    w_busy_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt = c_ST_ASSERT;
                    w_rst_n_nxt = '0;
                    w_hold_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
`ifdef HSID_RST_SEQ_ASYNC_ASSERT_EN
        // Raw request forces assertion immediately; release stays synchronous.
        rst_n_out = r_rst_n & {NUM_CH{rst_req_async_n}};
`else
        rst_n_out = r_rst_n;
`endif
        seq_busy  = r_busy;
        seq_done  = r_done;
        rst_cause = r_cause;
    end

endmodule
`default_nettype wire

// File: tb/tb_hsid_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hsid_rst_seq
// Brief    : Self-checking bench for hsid_rst_seq: directed vector table plus
//            randomized requests against a time-since-last-request model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hsid_rst_seq;

    localparam int c_NUM_CH = 4;
    localparam int c_SYNC   = 2;
    localparam int c_HOLD   = 16;
    localparam int c_STAG   = 4;
    localparam int c_LAST   = c_HOLD + (c_NUM_CH - 1) * c_STAG;
    localparam int c_NVEC   = 28;
`ifdef HSID_RST_SEQ_ASYNC_ASSERT_EN
    localparam bit c_ASYNC_EN = 1'b1;
`else
    localparam bit c_ASYNC_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rst_req_async_n = 1'b1;
    logic                sw_rst_req = 1'b0;
    logic [c_NUM_CH-1:0] rst_n_out;
    logic                seq_busy;
    logic                seq_done;
    logic [1:0]          rst_cause;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hsid_rst_seq #(
        .NUM_CH         (c_NUM_CH),
        .SYNC_STAGES    (c_SYNC),
        .HOLD_CYCLES    (c_HOLD),
        .STAGGER_CYCLES (c_STAG)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .rst_req_async_n (rst_req_async_n),
        .sw_rst_req      (sw_rst_req),
        .rst_n_out       (rst_n_out),
        .seq_busy        (seq_busy),
        .seq_done        (seq_done),
        .rst_cause       (rst_cause)
    );

    // Model: edges elapsed since the last reset/request decides everything.
    int         m_cnt = 0;
    logic [1:0] m_cause = 2'b00;
    logic       m_done = 1'b0;
    logic       m_hist [c_SYNC];

    task automatic model_edge();
        logic req_s;
        logic new_req;
        if (rst) begin
            m_cnt   = 0;
            m_cause = 2'b00;
            m_done  = 1'b0;
            for (int i = 0; i < c_SYNC; i++) m_hist[i] = 1'b1;
        end else begin
            req_s   = !m_hist[c_SYNC-1];
            new_req = req_s || sw_rst_req;
            if (new_req) begin
                m_cnt   = 0;
                m_cause = req_s ? 2'b01 : 2'b10;
            end else if (m_cnt <= c_LAST) begin
                m_cnt++;
            end
            m_done = !new_req && (m_cnt == c_LAST);
            for (int i = c_SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = rst_req_async_n;
        end
    endtask

    function automatic logic [c_NUM_CH-1:0] gate(input logic [c_NUM_CH-1:0] v);
        return c_ASYNC_EN ? (v & {c_NUM_CH{rst_req_async_n}}) : v;
    endfunction

    function automatic logic [c_NUM_CH-1:0] model_out();
        logic [c_NUM_CH-1:0] o;
        for (int k = 0; k < c_NUM_CH; k++) o[k] = (m_cnt >= c_HOLD + k * c_STAG);
        return gate(o);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        int                  n;
        logic                r;
        logic                an;
        logic                sw;
        logic [c_NUM_CH-1:0] out;
        logic                busy;
        logic                done;
        logic [1:0]          cause;
    } vec_t;

    vec_t vecs [c_NVEC];
    logic [c_NUM_CH-1:0] exp_async;

    initial begin
        // POR sequence
        vecs[0]  = '{3,  1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b00};
        vecs[1]  = '{15, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b00};
        vecs[2]  = '{1,  1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 2'b00};
        vecs[3]  = '{3,  1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 2'b00};
        vecs[4]  = '{1,  1'b0, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 2'b00};
        vecs[5]  = '{4,  1'b0, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b0, 2'b00};
        vecs[6]  = '{3,  1'b0, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b0, 2'b00};
        vecs[7]  = '{1,  1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 2'b00};
        vecs[8]  = '{1,  1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00};
        vecs[9]  = '{5,  1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00};
        // external pulse of three cycles while running
        vecs[10] = '{2,  1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00};
        vecs[11] = '{1,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b01};
        vecs[12] = '{17, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b01};
        vecs[13] = '{1,  1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 2'b01};
        vecs[14] = '{4,  1'b0, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 2'b01};
        // software abort right after channel 1 release
        vecs[15] = '{1,  1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'b10};
        vecs[16] = '{15, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b10};
        vecs[17] = '{1,  1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 2'b10};
        vecs[18] = '{12, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 2'b10};
        vecs[19] = '{1,  1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b10};
        // software pulse coincides with synchronised external request
        vecs[20] = '{2,  1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b10};
        vecs[21] = '{1,  1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'b01};
        vecs[22] = '{3,  1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b01};
        vecs[23] = '{27, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 2'b01};
        vecs[24] = '{2,  1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b01};
        // power-on reset pulse while running
        vecs[25] = '{1,  1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b00};
        vecs[26] = '{16, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 2'b00};
        vecs[27] = '{12, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 2'b00};

        for (int v = 0; v < c_NVEC; v++) begin
            rst             = vecs[v].r;
            rst_req_async_n = vecs[v].an;
            sw_rst_req      = vecs[v].sw;
            repeat (vecs[v].n) step();
            check($sformatf("vec%0d rst_n_out", v), 32'(rst_n_out), 32'(gate(vecs[v].out)));
            check($sformatf("vec%0d seq_busy", v), 32'(seq_busy), 32'(vecs[v].busy));
            check($sformatf("vec%0d seq_done", v), 32'(seq_done), 32'(vecs[v].done));
            check($sformatf("vec%0d rst_cause", v), 32'(rst_cause), 32'(vecs[v].cause));
        end

        // Request falling between edges: only the async-assert build reacts before an edge.
        #3;
        rst_req_async_n = 1'b0;
        #1;
        exp_async = c_ASYNC_EN ? 4'b0000 : 4'b1111;
        check("async_between_edges", 32'(rst_n_out), 32'(exp_async));
        #2;
        rst_req_async_n = 1'b1;

        // Randomized phase, starting from a fresh reset so model and DUT agree.
        rst        = 1'b1;
        sw_rst_req = 1'b0;
        step();
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            sw_rst_req = ($urandom_range(0, 119) == 0);
            if (rst_req_async_n) begin
                if ($urandom_range(0, 99) == 0) rst_req_async_n = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                rst_req_async_n = 1'b1;
            end
            step();
            check($sformatf("rand%0d state", c),
                  32'({rst_n_out, seq_busy, seq_done, rst_cause}),
                  32'({model_out(), (m_cnt < c_LAST), m_done, m_cause}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hsid_rst_seq.md
# hsid_rst_seq

Parametrised reset sequencer, the successor to the single-output reset synchroniser. It accepts a raw external reset request and a software reset pulse. It drives `NUM_CH` active-low reset outputs that are asserted together and released one at a time in a staggered order, after a programmable minimum hold time. It sits at the top of the clock domain and feeds the subsystem resets: channel 0 is released first and channel `NUM_CH-1` last.

## Interface
- `NUM_CH`, 4: number of reset output channels; must be ≥1.
- `SYNC_STAGES`, 2: synchroniser depth for `rst_req_async_n`; must be ≥2.
- `HOLD_CYCLES`, 16: minimum cycles all outputs stay asserted after the last request; must be ≥1.
- `STAGGER_CYCLES`, 4: cycles between consecutive channel releases; must be ≥1.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  synchronous, active-high power-on reset.
- `rst_req_async_n`  in  1  asynchronous external reset request, active-low, passed through a `SYNC_STAGES` flop chain.
- `sw_rst_req`  in  1  synchronous software reset request, one-cycle pulse.
- `rst_n_out`  out  NUM_CH  per-channel reset, active-low.
- `seq_busy`  out  1  high whenever any channel is still held in reset.
- `seq_done`  out  1  one-cycle pulse on the edge that releases the last channel.
- `rst_cause`  out  2  cause of the most recent reset: 00 = POR, 01 = external, 10 = software.

## Operation
- The synchroniser flops reset to 1, meaning no request. `req_s` is the synchronised request, active when the last flop is 0.
- The FSM has three states: ASSERT, RELEASE and RUN.
- Reset values: state = ASSERT, `hold_cnt` = 0, `stag_cnt` = 0, `ch_idx` = 1, `rst_n_out` = all 0, `seq_busy` = 1, `seq_done` = 0, `rst_cause` = 00.
- A new request is `req_s` active or `sw_rst_req` = 1. In any state, a new request has priority over every other transition. On the next edge:
  - state becomes ASSERT;
  - `rst_n_out` becomes all 0, `hold_cnt` = 0, `seq_busy` = 1;
  - `rst_cause` becomes 01 if `req_s` is active (this includes the case where both requests are active), otherwise 10.
- ASSERT with no new request:
  - if `hold_cnt` ≠ `HOLD_CYCLES-1`, increment `hold_cnt`;
  - otherwise go to RELEASE, set `rst_n_out[0]` = 1, `ch_idx` = 1, `stag_cnt` = 0.
  - If `NUM_CH` = 1, go directly to RUN instead and pulse `seq_done`.
- RELEASE with no new request:
  - if `stag_cnt` ≠ `STAGGER_CYCLES-1`, increment `stag_cnt`;
  - otherwise set `rst_n_out[ch_idx]` = 1, `stag_cnt` = 0, and increment `ch_idx`.
  - If `ch_idx` was `NUM_CH-1`, go to RUN, set `seq_busy` = 0 and pulse `seq_done`.
- RUN: outputs all 1 and hold until a new request arrives.
- Counter widths are `$clog2` of the respective maximum, with a minimum of 1. Counters never wrap, because their compare values bound them.
- Once released, a channel stays released until the next ASSERT. Outputs are registered and glitch-free.

## Timing
- Edge 1 is the first rising edge with `rst` = 0. Channel k is released on edge `HOLD_CYCLES + k*STAGGER_CYCLES`.
- `seq_done` is high for exactly the one cycle after edge `HOLD_CYCLES + (NUM_CH-1)*STAGGER_CYCLES`. A sequence aborted by a new request never pulses `seq_done`.
- External request assertion: `rst_n_out` goes all 0 on edge `SYNC_STAGES+1` after the fall of `rst_req_async_n` (worst case +1 edge for metastability resolution).
- `sw_rst_req` assertion: `rst_n_out` goes all 0 on the edge after the pulse is sampled.
- While `req_s` stays active, the block remains in ASSERT with `hold_cnt` = 0. Channel 0 is released `HOLD_CYCLES` edges after the first edge that samples `req_s` inactive.
- `rst` asserted mid-operation: on the next edge, all registers return to their reset values, including `rst_cause` = 00.

## Configuration
- `HSID_RST_SEQ_ASYNC_ASSERT_EN` defined: each `rst_n_out` bit is the registered value ANDed combinationally with raw `rst_req_async_n`. Assertion is therefore immediate and asynchronous; release still follows the synchronised sequence.
- Undefined: outputs are purely registered and assertion follows the latency given above.

## Test plan
All scenarios use `NUM_CH`=4, `SYNC_STAGES`=2, `HOLD_CYCLES`=16, `STAGGER_CYCLES`=4, with a 10 ns clock.
- POR: `rst` high for 3 cycles, then low → `rst_n_out` bits 0..3 rise on edges 16, 20, 24, 28; `seq_done` pulses after edge 28; `seq_busy` falls with it; `rst_cause` = 00.
- External pulse in RUN: `rst_req_async_n` low 7 ns after an edge for 30 ns → `rst_n_out` = 0000 on the 3rd edge after the fall; `rst_cause` = 01; bit 0 rises 16 edges after `req_s` is sampled inactive.
- Software abort mid-RELEASE: `sw_rst_req` pulse just after bit 1 is released → 0000 on the next edge; `rst_cause` = 10; full 16/4 sequence restarts with no `seq_done` from the aborted run.
- Simultaneous requests: `sw_rst_req` and synchronised external request active in the same cycle → `rst_cause` = 01.
- `rst` pulse during RUN → next edge `rst_n_out` = 0000, `seq_busy` = 1, `rst_cause` = 00; sequence replays as in POR.
- With `HSID_RST_SEQ_ASYNC_ASSERT_EN`: `rst_req_async_n` falls between edges → `rst_n_out` = 0000 within the same delta, before any clock edge. Without the macro, the output changes only at edge 3.
